// File: rtl/ps2_scancode_rx.sv
// PS/2 device-to-host receiver: synchronizes and deglitches the raw PS/2
// lines, frames 11-bit packets and delivers validated 8-bit scancodes.
//
// Ports:
//   clk_in     system clock
//   reset      synchronous, active-high reset
//   ps2_clock  raw PS/2 clock line (asynchronous)
//   ps2_data   raw PS/2 data line (asynchronous)
//   scancode   last correctly received byte
//   valid      one-cycle pulse, scancode just updated
//   parity_err one-cycle pulse, frame rejected for bad odd parity
//   frame_err  one-cycle pulse, frame rejected for stop bit = 0 or timeout
//   busy       high while a frame is in progress
//   err_count  saturating count of rejected frames
module ps2_scancode_rx #(
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic       clk_in,
  input  logic       reset,
  input  logic       ps2_clock,
  input  logic       ps2_data,
  output logic [7:0] scancode,
  output logic       valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       busy,
  output logic [7:0] err_count
);

  localparam int unsigned DATA_W = 8;
  localparam int unsigned FILT_W = 8;
  localparam int unsigned BIT_W  = 3;
  localparam int unsigned TO_W   = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  state_t              state_q, state_d;
  logic                clk_s1, clk_s2, dat_s1, dat_s2;
  logic [FILT_W-1:0]   filt_cnt;
  logic                clk_filt, clk_filt_d;
  logic [BIT_W-1:0]    bit_cnt;
  logic [DATA_W-1:0]   shift_q;
  logic                par_q;
  logic [TO_W-1:0]     to_cnt;

  logic fall_c, timeout_c, stop_fall_c, parity_ok_c;
  logic valid_c, parity_err_c, frame_err_c;

  // Two-flop synchronizers; idle-high reset avoids a spurious edge.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      clk_s1 <= 1'b1;
      clk_s2 <= 1'b1;
      dat_s1 <= 1'b1;
      dat_s2 <= 1'b1;
    end else begin
      clk_s1 <= ps2_clock;
      clk_s2 <= clk_s1;
      dat_s1 <= ps2_data;
      dat_s2 <= dat_s1;
    end
  end

  // Glitch filter: level flips after FILTER_LEN consecutive differing samples.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      filt_cnt   <= '0;
      clk_filt   <= 1'b1;
      clk_filt_d <= 1'b1;
    end else begin
      clk_filt_d <= clk_filt;
      if (clk_s2 == clk_filt) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FILT_W'(FILTER_LEN - 1)) begin
        clk_filt <= clk_s2;
        filt_cnt <= '0;
      end else begin
        filt_cnt <= filt_cnt + FILT_W'(1);
      end
    end
  end

  assign fall_c    = clk_filt_d & ~clk_filt;
  // A fall in the expiry cycle keeps the frame alive.
  assign timeout_c = (state_q != IDLE) && !fall_c &&
                     (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  // State register.
  always_ff @(posedge clk_in) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    if (timeout_c) begin
      state_d = IDLE;
    end else if (fall_c) begin
      unique case (state_q)
        IDLE:    if (!dat_s2) state_d = DATA;
        DATA:    if (bit_cnt == BIT_W'(DATA_W - 1)) state_d = PARITY;
        PARITY:  state_d = STOP;
        STOP:    state_d = IDLE;
      endcase
    end
  end

  // Frame result decode; parity error takes precedence over a bad stop bit.
  always_comb begin
    stop_fall_c  = fall_c && (state_q == STOP);
    parity_ok_c  = ^{shift_q, par_q};
    valid_c      = stop_fall_c && parity_ok_c && dat_s2;
    parity_err_c = stop_fall_c && !parity_ok_c;
    frame_err_c  = (stop_fall_c && parity_ok_c && !dat_s2) || timeout_c;
  end

  // Shift register, bit counter and inter-edge timeout counter.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      bit_cnt <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      to_cnt  <= '0;
    end else begin
      if (fall_c) begin
        unique case (state_q)
          IDLE:    bit_cnt <= '0;
          DATA: begin
            shift_q <= {dat_s2, shift_q[DATA_W-1:1]};
            bit_cnt <= bit_cnt + BIT_W'(1);
          end
          PARITY:  par_q <= dat_s2;
          STOP:    ;
        endcase
      end
      if ((state_q == IDLE) || fall_c || timeout_c) to_cnt <= '0;
      else                                          to_cnt <= to_cnt + TO_W'(1);
    end
  end

  // Registered outputs.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      scancode   <= '0;
      valid      <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
      err_count  <= '0;
    end else begin
      valid      <= valid_c;
      parity_err <= parity_err_c;
      frame_err  <= frame_err_c;
      busy       <= (state_d != IDLE);
      if (valid_c) scancode <= shift_q;
      if ((parity_err_c || frame_err_c) && (err_count != 8'hFF))
        err_count <= err_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// Testbench for ps2_scancode_rx: table-driven frames, randomized frames
// against a frame-level reference model, and hand sequences for timeout,
// glitch rejection and mid-frame reset.
module tb_ps2_scancode_rx;

  localparam int unsigned FL = 8;
  localparam int unsigned TO = 400;
  localparam int          HALF = 30;

  logic       clk_in = 1'b0;
  logic       reset;
  logic       ps2_clock;
  logic       ps2_data;
  logic [7:0] scancode;
  logic       valid;
  logic       parity_err;
  logic       frame_err;
  logic       busy;
  logic [7:0] err_count;

  ps2_scancode_rx #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
    .clk_in(clk_in), .reset(reset), .ps2_clock(ps2_clock), .ps2_data(ps2_data),
    .scancode(scancode), .valid(valid), .parity_err(parity_err),
    .frame_err(frame_err), .busy(busy), .err_count(err_count)
  );

  always #5 clk_in = ~clk_in;

  // kind: 0 = valid, 1 = parity_err, 2 = frame_err
  typedef struct {
    int         kind;
    logic [7:0] code;
    int         cyc;
  } ev_t;

  typedef struct {
    logic [7:0] d;
    bit         bad_par;
    bit         stop;
    int         exp_kind;
    logic [7:0] exp_sc;
  } vec_t;

  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  ev_t  evq[$];
  logic busy_q = 1'b0;
  int   busy_rise_cyc = -1;
  int   busy_fall_cyc = -1;
  int   busy_rises = 0;
  logic [7:0] sc_exp = 8'h00;
  int   err_exp = 0;

  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Output monitor: logs every result pulse and busy transitions.
  always @(negedge clk_in) begin
    if (valid)      evq.push_back('{0, scancode, cyc});
    if (parity_err) evq.push_back('{1, scancode, cyc});
    if (frame_err)  evq.push_back('{2, scancode, cyc});
    if (valid || parity_err || frame_err) chk("busy_at_pulse", 32'(busy), 32'd0);
    if (busy && !busy_q) begin busy_rise_cyc = cyc; busy_rises++; end
    if (!busy && busy_q) busy_fall_cyc = cyc;
    busy_q = busy;
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  task automatic send_bit(input logic b, input int half, output int k_fall);
    ps2_data = b;
    wait_cyc(half);
    ps2_clock = 1'b0;
    k_fall = cyc;
    wait_cyc(half);
    ps2_clock = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input bit bad_par, input bit stop,
                            input int half, output int k_start, output int k_stop);
    int   k;
    logic par;
    par = ~(^d) ^ bad_par;
    send_bit(1'b0, half, k_start);
    for (int i = 0; i < 8; i++) send_bit(d[i], half, k);
    send_bit(par, half, k);
    send_bit(stop, half, k_stop);
    ps2_data = 1'b1;
  endtask

  // Reference: classify a transmitted frame from its bits alone.
  function automatic int model_kind(input logic [7:0] d, input bit bad_par, input bit stop);
    int ones;
    logic par;
    par  = ~(^d) ^ bad_par;
    ones = $countones(d) + int'(par);
    if ((ones % 2) != 1) return 1;
    if (!stop)           return 2;
    return 0;
  endfunction

  task automatic expect_result(input string tag, input int kind, input logic [7:0] code,
                               output int ev_cyc);
    ev_t e;
    wait_cyc(20);
    chk({tag, "_nevents"}, 32'(evq.size()), 32'd1);
    ev_cyc = -1;
    if (evq.size() > 0) begin
      e = evq.pop_front();
      chk({tag, "_kind"}, 32'(e.kind), 32'(kind));
      ev_cyc = e.cyc;
    end
    evq.delete();
    if (kind == 0) sc_exp = code;
    else if (err_exp < 255) err_exp++;
    chk({tag, "_scancode"}, 32'(scancode), 32'(sc_exp));
    chk({tag, "_err_count"}, 32'(err_count), 32'(err_exp));
  endtask

  vec_t vecs[7];

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got no completion, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int ks, kp, kl, ec, nr;
    logic [7:0] d;
    bit bad, stp;
    int half, kind;

    vecs[0] = '{8'h1C, 1'b0, 1'b1, 0, 8'h1C};
    vecs[1] = '{8'hF0, 1'b0, 1'b1, 0, 8'hF0};
    vecs[2] = '{8'h1C, 1'b0, 1'b1, 0, 8'h1C};
    vecs[3] = '{8'h5A, 1'b1, 1'b1, 1, 8'h1C};
    vecs[4] = '{8'h29, 1'b0, 1'b0, 2, 8'h1C};
    vecs[5] = '{8'h29, 1'b1, 1'b0, 1, 8'h1C};
    vecs[6] = '{8'h29, 1'b0, 1'b1, 0, 8'h29};

    reset = 1'b1; ps2_clock = 1'b1; ps2_data = 1'b1;
    wait_cyc(5);
    chk("rst_scancode", 32'(scancode), 32'h0);
    chk("rst_valid", 32'(valid), 32'h0);
    chk("rst_parity_err", 32'(parity_err), 32'h0);
    chk("rst_frame_err", 32'(frame_err), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_err_count", 32'(err_count), 32'h0);
    reset = 1'b0;
    wait_cyc(10);

    // Frame 0x1C with latency checks: raw edge, 2 sync stages, FL filter
    // samples, then the registered result one cycle after the fall cycle.
    send_frame(8'h1C, 1'b0, 1'b1, HALF, ks, kp);
    expect_result("a_1c", 0, 8'h1C, ec);
    chk("a_pulse_cycle", 32'(ec), 32'(kp + 3 + int'(FL)));
    chk("a_busy_rise", 32'(busy_rise_cyc), 32'(ks + 3 + int'(FL)));
    chk("a_busy_fall", 32'(busy_fall_cyc), 32'(ec));

    foreach (vecs[i]) begin
      send_frame(vecs[i].d, vecs[i].bad_par, vecs[i].stop, HALF, ks, kp);
      expect_result($sformatf("vec%0d", i), vecs[i].exp_kind, vecs[i].d, ec);
      chk($sformatf("vec%0d_sc", i), 32'(scancode), 32'(vecs[i].exp_sc));
      wait_cyc(10);
    end

    for (int i = 0; i < 20; i++) begin
      d    = 8'($urandom);
      bad  = ($urandom_range(0, 3) == 0);
      stp  = ($urandom_range(0, 3) != 0);
      half = int'($urandom_range(14, 40));
      kind = model_kind(d, bad, stp);
      send_frame(d, bad, stp, half, ks, kp);
      expect_result($sformatf("rnd%0d", i), kind, d, ec);
      wait_cyc(int'($urandom_range(5, 50)));
    end

    // Timeout: start bit plus three data bits, then the line goes idle.
    send_bit(1'b0, HALF, kl);
    send_bit(1'b1, HALF, kl);
    send_bit(1'b0, HALF, kl);
    send_bit(1'b0, HALF, kl);
    ps2_data = 1'b1;
    wait_cyc(int'(TO) + 10);
    expect_result("timeout", 2, 8'h00, ec);
    chk("timeout_cycle", 32'(ec), 32'(kl + 3 + int'(FL) + int'(TO)));
    chk("timeout_busy", 32'(busy), 32'd0);
    send_frame(8'h29, 1'b0, 1'b1, HALF, ks, kp);
    expect_result("after_to", 0, 8'h29, ec);

    // Short glitch on the clock line while idle must not start a frame.
    nr = busy_rises;
    ps2_data = 1'b0;
    ps2_clock = 1'b0;
    wait_cyc(3);
    ps2_clock = 1'b1;
    wait_cyc(40);
    chk("glitch_events", 32'(evq.size()), 32'd0);
    chk("glitch_busy_rises", 32'(busy_rises), 32'(nr));
    chk("glitch_busy", 32'(busy), 32'd0);
    ps2_data = 1'b1;
    wait_cyc(10);

    // Reset after the fourth data bit of 0x45 drops the partial frame.
    send_bit(1'b0, HALF, kl);
    for (int i = 0; i < 4; i++) send_bit(d[0] ^ d[0] ^ ((8'h45 >> i) & 8'h01) != 0, HALF, kl);
    reset = 1'b1;
    wait_cyc(1);
    chk("mrst_scancode", 32'(scancode), 32'h0);
    chk("mrst_valid", 32'(valid), 32'h0);
    chk("mrst_parity_err", 32'(parity_err), 32'h0);
    chk("mrst_frame_err", 32'(frame_err), 32'h0);
    chk("mrst_busy", 32'(busy), 32'h0);
    chk("mrst_err_count", 32'(err_count), 32'h0);
    reset = 1'b0;
    ps2_data = 1'b1;
    sc_exp = 8'h00;
    err_exp = 0;
    wait_cyc(10);
    chk("mrst_events", 32'(evq.size()), 32'd0);
    evq.delete();
    send_frame(8'h45, 1'b0, 1'b1, HALF, ks, kp);
    expect_result("post_rst", 0, 8'h45, ec);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
